bus_read_mux: RTL and testbench
===============================

Name: bus_read_mux

Overview:
- Parametrised read-data return mux for the CPU data bus.
- Selects one of NUM_SLV slave read-data buses (data memory, TBMAN, future peripherals) and returns it to the load path.
- Generalises the fixed two-slave combinational mux:
  - configurable slave count and data width;
  - selection delayed to match synchronous-memory read latency;
  - an explicit hold register replacing the inferred latch;
  - a read-valid strobe and multi-select detection.

Parameters:
- NUM_SLV, 2, number of slave channels (2..16); channel 0 has the highest priority.
- DATA_W, 32, read-data width in bits.
- RD_LAT, 1, cycles from address phase (rd_en plus cs_n) to slave data valid; legal values 0, 1, 2.
- HOLD_INIT, 32'h0000_0000, reset value of the hold register. Truncated or zero-extended to DATA_W.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- rd_en  input  1  load access issued this cycle (address phase).
- cs_n  input  NUM_SLV  active-low slave chip selects, address phase, bit i = slave i.
- rd_data_in  input  NUM_SLV*DATA_W  flattened slave read data; slice i is [i*DATA_W +: DATA_W].
- read_data  output  DATA_W  data returned to CPU.
- read_valid  output  1  read_data carries a fresh slave response this cycle.
- sel_idx  output  4  index of the slave currently returning data; holds its last value when read_valid=0.
- multi_sel  output  1  one-cycle pulse: address phase had more than one cs_n low with rd_en=1.

Behaviour:
- Reset (rst=1, asynchronous):
  - hold register = HOLD_INIT; read_data = HOLD_INIT.
  - read_valid=0, sel_idx=0, multi_sel=0, all pipeline stages cleared (valid=0).
- Address phase accept: hit = rd_en & (any cs_n bit low). Encoded index = lowest i with cs_n[i]=0 (priority encoder).
- Pipeline: {hit, index} pass through RD_LAT register stages.
  - RD_LAT=0: no stages; behaviour is combinational on the current cycle.
  - Stage shift every cycle, no stall input; the CPU guarantees no bus stall.
- Response cycle, when the stage output has valid=1:
  - read_data = slice[index] of rd_data_in in that same cycle (combinational through the mux).
  - read_valid=1, sel_idx=index.
  - The hold register loads that value at the next rising edge.
- Non-response cycle (valid=0): read_data = hold register; read_valid=0.
- rd_en=0 with cs_n low (write access): ignored, no pipeline entry.
- rd_en=1 with all cs_n high: no entry. read_data keeps the hold value; this is decoded-hole behaviour.
- Multi-select: priority winner is used. multi_sel is registered and asserts the cycle after the address phase, for one cycle, for any RD_LAT.
- Back-to-back reads: one response per cycle, in order, with no bubble between accesses.
- Reset mid-flight: all in-flight entries are discarded; no read_valid pulse after rst deasserts for accesses issued before reset.
- Indices of NUM_SLV or greater cannot occur; sel_idx upper bits are zero.

Optional Feature:
- Macro BUS_RD_ERR_EN.
- When defined:
  - Adds output bus_err (1 bit) and output err_cnt (8 bits, saturating at 8'hFF, reset 0).
  - A read address phase with all cs_n high (decoded hole), or multi-select, enters the pipeline as an error entry.
  - At its response cycle: read_data = 32'hDEAD_BEEF truncated to DATA_W, read_valid=1, bus_err=1 for one cycle, err_cnt increments. The hold register is not updated.
- When undefined: the ports are absent, holes behave as above (no entry, hold value), and multi-select only pulses multi_sel.

Test Plan:
- Reset with HOLD_INIT=32'h1234_5678, NUM_SLV=2, RD_LAT=1 -> read_data=32'h1234_5678, read_valid=0, sel_idx=0.
- RD_LAT=1, cycle0 rd_en=1, cs_n=2'b10, cycle1 slave0 data 32'hA5A5_0001 -> cycle1 read_data=32'hA5A5_0001, read_valid=1, sel_idx=0; cycle2 read_valid=0, read_data stays 32'hA5A5_0001.
- RD_LAT=2, back-to-back reads to slave1 (32'h0000_00B1) then slave0 (32'h0000_00A0) in cycles 0,1 -> valid in cycles 2 and 3 with those values, sel_idx 1 then 0.
- NUM_SLV=4, cs_n=4'b0101 with rd_en=1 -> multi_sel pulses next cycle; response taken from slave1.
- Read issued at cycle0 (RD_LAT=2), rst pulsed in cycle1 -> no read_valid in cycles 2-3; read_data=HOLD_INIT.
- BUS_RD_ERR_EN defined, rd_en=1, cs_n all high -> response cycle read_data=32'hDEAD_BEEF, bus_err=1, err_cnt 0->1; 300 such reads -> err_cnt=8'hFF.

Source files
------------

// File: rtl/bus_read_mux.sv
// Read-data return mux: priority-selects one of NUM_SLV slave buses, delays the select by RD_LAT to match memory latency.
// Optional macro BUS_RD_ERR_EN adds bus_err/err_cnt and turns decoded holes and multi-selects into error responses.
module bus_read_mux #(
    parameter int unsigned NUM_SLV   = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RD_LAT    = 1,
    parameter logic [31:0] HOLD_INIT = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_en,
    input  logic [NUM_SLV-1:0]        cs_n,
    input  logic [NUM_SLV*DATA_W-1:0] rd_data_in,
    output logic [DATA_W-1:0]         read_data,
    output logic                      read_valid,
    output logic [3:0]                sel_idx,
    output logic                      multi_sel
`ifdef BUS_RD_ERR_EN
    ,
    output logic                      bus_err,
    output logic [7:0]                err_cnt
`endif
);

    localparam int unsigned IDX_W = 4;
    localparam logic [DATA_W-1:0] HOLD_RST = DATA_W'(HOLD_INIT);
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

    logic [NUM_SLV-1:0] sel_vec;
    logic               any_sel;
    logic               multi_hit;
    logic [IDX_W-1:0]   enc_idx;
    logic               entry_vld;
    logic               entry_err;

    assign sel_vec   = ~cs_n;
    assign any_sel   = |sel_vec;
    // More than one bit set iff clearing the lowest set bit leaves something behind.
    assign multi_hit = |(sel_vec & (sel_vec - NUM_SLV'(1)));

    // Priority encoder: lowest asserted select wins.
    always_comb begin
        enc_idx = '0;
        for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
            if (sel_vec[i]) begin
                enc_idx = IDX_W'(i);
            end
        end
    end

`ifdef BUS_RD_ERR_EN
    assign entry_vld = rd_en;
    assign entry_err = ~any_sel | multi_hit;
`else
    assign entry_vld = rd_en & any_sel;
    assign entry_err = 1'b0;
`endif

    logic             rsp_vld;
    logic             rsp_err;
    logic [IDX_W-1:0] rsp_idx;

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign rsp_vld = entry_vld & ~rst;
            assign rsp_err = entry_err;
            assign rsp_idx = enc_idx;
        end else begin : g_pipe
            localparam int unsigned IDX_PIPE_W = IDX_W * RD_LAT;

            logic [RD_LAT-1:0]     vld_q;
            logic [RD_LAT-1:0]     err_q;
            logic [IDX_PIPE_W-1:0] idx_q;

            // Stage 0 sits in the low bits; entries shift upward each cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                    err_q <= '0;
                    idx_q <= '0;
                end else begin
                    vld_q <= RD_LAT'({vld_q, entry_vld});
                    err_q <= RD_LAT'({err_q, entry_err});
                    idx_q <= IDX_PIPE_W'({idx_q, enc_idx});
                end
            end

            assign rsp_vld = vld_q[RD_LAT-1];
            assign rsp_err = err_q[RD_LAT-1];
            assign rsp_idx = idx_q[IDX_PIPE_W-1 -: IDX_W];
        end
    endgenerate

    logic [DATA_W-1:0] mux_data;
    logic [DATA_W-1:0] hold_q;
    logic [IDX_W-1:0]  sel_q;
    logic              rsp_good;

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            if (rsp_idx == IDX_W'(i)) begin
                mux_data = rd_data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rsp_good = rsp_vld & ~rsp_err;

    always_comb begin
        read_valid = rsp_vld;
        read_data  = hold_q;
        sel_idx    = sel_q;
        if (rsp_good) begin
            read_data = mux_data;
            sel_idx   = rsp_idx;
        end else if (rsp_vld) begin
            read_data = ERR_DATA;
        end
    end

    // Hold register and last-index register replace the old inferred latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= HOLD_RST;
            sel_q     <= '0;
            multi_sel <= 1'b0;
        end else begin
            multi_sel <= rd_en & multi_hit;
            if (rsp_good) begin
                hold_q <= mux_data;
                sel_q  <= rsp_idx;
            end
        end
    end

`ifdef BUS_RD_ERR_EN
    assign bus_err = rsp_vld & rsp_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if (bus_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_bus_read_mux.sv
// Bench for bus_read_mux: four instances with different slave counts and latencies, checked every cycle against a history-based model.
module tb_bus_read_mux;

    localparam int HMAX = 2048;
    localparam int          NS   [4] = '{4, 2, 2, 4};
    localparam int          LAT  [4] = '{0, 1, 2, 1};
    localparam logic [31:0] INIT [4] = '{32'h0000_0000, 32'h1234_5678, 32'hCAFE_0002, 32'h0BAD_0003};

    logic         clk;
    logic         rst;
    logic         rd_en;
    logic [3:0]   cs_n;
    logic [127:0] rd_data_in;

    logic [31:0] rdata  [4];
    logic        rvalid [4];
    logic [3:0]  sidx   [4];
    logic        msel   [4];
`ifdef BUS_RD_ERR_EN
    logic        berr   [4];
    logic [7:0]  ecnt   [4];
`endif

    int n_chk = 0;
    int n_err = 0;
    int cyc   = -1;

    logic         h_rst  [HMAX];
    logic         h_rd   [HMAX];
    logic [3:0]   h_cs   [HMAX];
    logic [127:0] h_data [HMAX];

    logic [31:0] m_hold [4];
    logic [3:0]  m_sel  [4];
    int          m_ecnt [4];

    bus_read_mux #(.NUM_SLV(4), .DATA_W(32), .RD_LAT(0), .HOLD_INIT(32'h0000_0000)) u0 (
        .clk(clk), .rst(rst), .rd_en(rd_en), .cs_n(cs_n), .rd_data_in(rd_data_in),
        .read_data(rdata[0]), .read_valid(rvalid[0]), .sel_idx(sidx[0]), .multi_sel(msel[0])
`ifdef BUS_RD_ERR_EN
        , .bus_err(berr[0]), .err_cnt(ecnt[0])
`endif
    );
    bus_read_mux #(.NUM_SLV(2), .DATA_W(32), .RD_LAT(1), .HOLD_INIT(32'h1234_5678)) u1 (
        .clk(clk), .rst(rst), .rd_en(rd_en), .cs_n(cs_n[1:0]), .rd_data_in(rd_data_in[63:0]),
        .read_data(rdata[1]), .read_valid(rvalid[1]), .sel_idx(sidx[1]), .multi_sel(msel[1])
`ifdef BUS_RD_ERR_EN
        , .bus_err(berr[1]), .err_cnt(ecnt[1])
`endif
    );
    bus_read_mux #(.NUM_SLV(2), .DATA_W(32), .RD_LAT(2), .HOLD_INIT(32'hCAFE_0002)) u2 (
        .clk(clk), .rst(rst), .rd_en(rd_en), .cs_n(cs_n[1:0]), .rd_data_in(rd_data_in[63:0]),
        .read_data(rdata[2]), .read_valid(rvalid[2]), .sel_idx(sidx[2]), .multi_sel(msel[2])
`ifdef BUS_RD_ERR_EN
        , .bus_err(berr[2]), .err_cnt(ecnt[2])
`endif
    );
    bus_read_mux #(.NUM_SLV(4), .DATA_W(32), .RD_LAT(1), .HOLD_INIT(32'h0BAD_0003)) u3 (
        .clk(clk), .rst(rst), .rd_en(rd_en), .cs_n(cs_n), .rd_data_in(rd_data_in),
        .read_data(rdata[3]), .read_valid(rvalid[3]), .sel_idx(sidx[3]), .multi_sel(msel[3])
`ifdef BUS_RD_ERR_EN
        , .bus_err(berr[3]), .err_cnt(ecnt[3])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] dat(input logic [31:0] d0, input logic [31:0] d1,
                                         input logic [31:0] d2, input logic [31:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic reset_in(input int a, input int b);
        for (int c = a; c <= b; c++) begin
            if (h_rst[c]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // A response at cycle t comes from the address phase LAT cycles earlier, unless reset hit that window.
    function automatic void model_rsp(input int k, input int t, output logic vld,
                                      output logic err, output logic [3:0] idx);
        int         s;
        int         cnt;
        logic [3:0] sel;
        vld = 1'b0;
        err = 1'b0;
        idx = 4'd0;
        s   = t - LAT[k];
        if (s < 0 || reset_in(s, t) || !h_rd[s]) return;
        sel = ~h_cs[s] & 4'((1 << NS[k]) - 1);
        cnt = $countones(sel);
        for (int i = 3; i >= 0; i--) begin
            if (sel[i]) idx = 4'(i);
        end
`ifdef BUS_RD_ERR_EN
        vld = 1'b1;
        err = (cnt != 1);
`else
        vld = (cnt > 0);
`endif
    endfunction

    function automatic logic model_multi(input int k, input int t);
        if (t < 1 || reset_in(t - 1, t) || !h_rd[t-1]) return 1'b0;
        return $countones(~h_cs[t-1] & 4'((1 << NS[k]) - 1)) > 1;
    endfunction

    // Single compare process: every cycle, every instance, every output.
    always @(negedge clk) begin
        if (cyc >= 0) begin
            for (int k = 0; k < 4; k++) begin
                logic        v;
                logic        e;
                logic [3:0]  ix;
                logic [31:0] ed;
                logic [3:0]  es;
                if (h_rst[cyc]) begin
                    m_hold[k] = INIT[k];
                    m_sel[k]  = 4'd0;
                    m_ecnt[k] = 0;
                end
                model_rsp(k, cyc, v, e, ix);
                ed = m_hold[k];
                es = m_sel[k];
                if (v && !e) begin
                    ed = h_data[cyc][ix*32 +: 32];
                    es = ix;
                end else if (v) begin
                    ed = 32'hDEAD_BEEF;
                end
                check($sformatf("u%0d read_data", k), rdata[k], ed);
                check($sformatf("u%0d read_valid", k), 32'(rvalid[k]), 32'(v));
                check($sformatf("u%0d sel_idx", k), 32'(sidx[k]), 32'(es));
                check($sformatf("u%0d multi_sel", k), 32'(msel[k]), 32'(model_multi(k, cyc)));
`ifdef BUS_RD_ERR_EN
                check($sformatf("u%0d bus_err", k), 32'(berr[k]), 32'(v && e));
                check($sformatf("u%0d err_cnt", k), 32'(ecnt[k]), 32'(m_ecnt[k]));
                if (v && e && m_ecnt[k] < 255) m_ecnt[k]++;
`endif
                if (v && !e) begin
                    m_hold[k] = ed;
                    m_sel[k]  = ix;
                end
            end
        end
    end

    task automatic step(input logic r, input logic rd, input logic [3:0] cs, input logic [127:0] d);
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= HMAX) begin
            $display("FAIL history_overflow: got %0d expected below %0d", cyc, HMAX);
            $fatal(1);
        end
        rst        = r;
        rd_en      = rd;
        cs_n       = cs;
        rd_data_in = d;
        h_rst[cyc]  = r;
        h_rd[cyc]   = rd;
        h_cs[cyc]   = cs;
        h_data[cyc] = d;
    endtask

    task automatic idle(input logic [127:0] d);
        step(1'b0, 1'b0, 4'hF, d);
    endtask

    initial begin
        logic [3:0] cs_tab [6];
        cs_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b1010};
        rst = 1'b1; rd_en = 1'b0; cs_n = 4'hF; rd_data_in = '0;
        for (int k = 0; k < 4; k++) begin
            m_hold[k] = INIT[k]; m_sel[k] = 4'd0; m_ecnt[k] = 0;
        end

        step(1'b1, 1'b0, 4'hF, dat(32'h1, 32'h2, 32'h3, 32'h4));           // 0: reset
        @(negedge clk);
        check("reset read_data", rdata[1], 32'h1234_5678);
        check("reset read_valid", 32'(rvalid[1]), 32'd0);
        check("reset sel_idx", 32'(sidx[1]), 32'd0);
        idle(dat(32'h10, 32'h11, 32'h12, 32'h13));                          // 1
        step(1'b0, 1'b1, 4'b1110, dat(32'h20, 32'h21, 32'h22, 32'h23));    // 2: read slave0
        idle(dat(32'hA5A5_0001, 32'h31, 32'h32, 32'h33));                   // 3
        @(negedge clk);
        check("lat1 read_data", rdata[1], 32'hA5A5_0001);
        check("lat1 read_valid", 32'(rvalid[1]), 32'd1);
        check("lat1 sel_idx", 32'(sidx[1]), 32'd0);
        idle(dat(32'h1111_1111, 32'h41, 32'h42, 32'h43));                   // 4
        @(negedge clk);
        check("lat1 hold valid", 32'(rvalid[1]), 32'd0);
        check("lat1 hold data", rdata[1], 32'hA5A5_0001);

        step(1'b0, 1'b1, 4'b1101, dat(32'h50, 32'h51, 32'h52, 32'h53));    // 5: slave1
        step(1'b0, 1'b1, 4'b1110, dat(32'h60, 32'h61, 32'h62, 32'h63));    // 6: slave0
        idle(dat(32'h77, 32'h0000_00B1, 32'h72, 32'h73));                   // 7
        @(negedge clk);
        check("lat2 first data", rdata[2], 32'h0000_00B1);
        check("lat2 first valid", 32'(rvalid[2]), 32'd1);
        check("lat2 first sel", 32'(sidx[2]), 32'd1);
        idle(dat(32'h0000_00A0, 32'h88, 32'h82, 32'h83));                   // 8
        @(negedge clk);
        check("lat2 second data", rdata[2], 32'h0000_00A0);
        check("lat2 second sel", 32'(sidx[2]), 32'd0);
        idle(dat(32'h90, 32'h91, 32'h92, 32'h93));                          // 9
        @(negedge clk);
        check("lat2 idle valid", 32'(rvalid[2]), 32'd0);

        step(1'b0, 1'b1, 4'b0101, dat(32'hA0, 32'hA1, 32'hA2, 32'hA3));    // 10: multi-select
        idle(dat(32'hB0, 32'h5151_0001, 32'hB2, 32'hB3));                   // 11
        @(negedge clk);
        check("multi pulse", 32'(msel[3]), 32'd1);
        check("multi narrow inst", 32'(msel[1]), 32'd0);
`ifndef BUS_RD_ERR_EN
        check("multi winner data", rdata[3], 32'h5151_0001);
        check("multi winner sel", 32'(sidx[3]), 32'd1);
`else
        check("multi err data", rdata[3], 32'hDEAD_BEEF);
        check("multi err flag", 32'(berr[3]), 32'd1);
`endif
        idle(dat(32'hC0, 32'hC1, 32'hC2, 32'hC3));                          // 12
        @(negedge clk);
        check("multi one cycle", 32'(msel[3]), 32'd0);

        step(1'b0, 1'b0, 4'b0000, dat(32'hD0, 32'hD1, 32'hD2, 32'hD3));    // 13: write access
        idle(dat(32'hE0, 32'hE1, 32'hE2, 32'hE3));                          // 14
        @(negedge clk);
        check("write ignored", 32'(rvalid[3]), 32'd0);
        step(1'b0, 1'b1, 4'hF, dat(32'hF0, 32'hF1, 32'hF2, 32'hF3));       // 15: decoded hole
        idle(dat(32'h160, 32'h161, 32'h162, 32'h163));                      // 16

        step(1'b0, 1'b1, 4'b1101, dat(32'h170, 32'h171, 32'h172, 32'h173)); // 17: read in flight
        step(1'b1, 1'b0, 4'hF, dat(32'h180, 32'h181, 32'h182, 32'h183));    // 18: reset
        idle(dat(32'h190, 32'h191, 32'h192, 32'h193));                      // 19
        @(negedge clk);
        check("flush valid c2", 32'(rvalid[2]), 32'd0);
        check("flush data c2", rdata[2], 32'hCAFE_0002);
        idle(dat(32'h200, 32'h201, 32'h202, 32'h203));                      // 20
        @(negedge clk);
        check("flush valid c3", 32'(rvalid[2]), 32'd0);
        check("flush data c3", rdata[2], 32'hCAFE_0002);

        step(1'b0, 1'b1, 4'b1011, dat(32'h210, 32'h211, 32'h0C0C_0C0C, 32'h213)); // 21: lat0 read
        @(negedge clk);
        check("lat0 data", rdata[0], 32'h0C0C_0C0C);
        check("lat0 valid", 32'(rvalid[0]), 32'd1);
        check("lat0 sel", 32'(sidx[0]), 32'd2);
        idle(dat(32'h220, 32'h221, 32'h222, 32'h223));                      // 22
        @(negedge clk);
        check("lat0 hold sel", 32'(sidx[0]), 32'd2);
        check("lat0 hold data", rdata[0], 32'h0C0C_0C0C);

        for (int n = 0; n < 60; n++) begin
            step(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0),
                 cs_tab[$urandom_range(0, 5)], dat($urandom, $urandom, $urandom, $urandom));
        end

`ifdef BUS_RD_ERR_EN
        step(1'b1, 1'b0, 4'hF, dat(32'h0, 32'h0, 32'h0, 32'h0));
        step(1'b0, 1'b1, 4'hF, dat(32'h1, 32'h2, 32'h3, 32'h4));
        idle(dat(32'h5, 32'h6, 32'h7, 32'h8));
        @(negedge clk);
        check("hole err data", rdata[1], 32'hDEAD_BEEF);
        check("hole err flag", 32'(berr[1]), 32'd1);
        check("hole err_cnt before", 32'(ecnt[1]), 32'd0);
        idle(dat(32'h9, 32'hA, 32'hB, 32'hC));
        @(negedge clk);
        check("hole err_cnt after", 32'(ecnt[1]), 32'd1);
        check("hole hold kept", rdata[1], 32'h1234_5678);
        for (int n = 0; n < 300; n++) begin
            step(1'b0, 1'b1, 4'hF, dat(32'(n), 32'(n + 1), 32'(n + 2), 32'(n + 3)));
        end
        idle(dat(32'h0, 32'h0, 32'h0, 32'h0));
        idle(dat(32'h0, 32'h0, 32'h0, 32'h0));
        @(negedge clk);
        check("err_cnt saturate", 32'(ecnt[1]), 32'h0000_00FF);
`endif

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
